// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the operand RAM port arbiter.
// Holds the default geometry (requesters, word width, address width), the
// RAM port encoding and a small index-wrap helper used by the round-robin
// pointer logic.
package ram_port_arbiter_pkg;

  localparam int N_REQ_DEF = 3;
  localparam int DATA_DEF  = 256;
  localparam int ADDR_DEF  = 2;

  // RAM port encoding: port A is the first winner of a scan, port B the second.
  typedef enum logic [0:0] {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Increment a requester index and wrap it back to zero at n.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 32'sd1;
    if (nxt >= n) begin
      nxt = 32'sd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rr_pick2: combinational round-robin picker returning up to two winners.
// The scan starts at rr_ptr and walks upward modulo N_REQ. The first
// eligible requester wins port A; the next eligible requester wins port B
// unless the clash mask marks it as a same-address write against A's winner,
// in which case it is skipped and the scan continues.
// Ports:
//   elig   in  N_REQ          eligible requesters this cycle
//   clash  in  N_REQ x N_REQ  clash[a][b]=1: a and b write the same address
//   rr_ptr in  PW             scan start index
//   a_vld  out 1              port A has a winner
//   a_idx  out PW             port A winner index
//   b_vld  out 1              port B has a winner
//   b_idx  out PW             port B winner index
module rr_pick2 #(
  parameter int N_REQ = 3,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [N_REQ-1:0] clash [N_REQ],
  input  logic [PW-1:0]    rr_ptr,
  output logic             a_vld,
  output logic [PW-1:0]    a_idx,
  output logic             b_vld,
  output logic [PW-1:0]    b_idx
);

  logic [PW:0]   pos_sum_s;
  logic [PW-1:0] pos_s;

  // Rotating scan selecting the port A and port B winners.
  always_comb begin
    a_vld     = 1'b0;
    a_idx     = '0;
    b_vld     = 1'b0;
    b_idx     = '0;
    pos_sum_s = '0;
    pos_s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos_sum_s = {1'b0, rr_ptr} + (PW+1)'(k);
      if (pos_sum_s >= (PW+1)'(N_REQ)) begin
        pos_sum_s = pos_sum_s - (PW+1)'(N_REQ);
      end else begin
        pos_sum_s = pos_sum_s;
      end
      pos_s = pos_sum_s[PW-1:0];
      if (elig[pos_s] && !a_vld) begin
        a_vld = 1'b1;
        a_idx = pos_s;
      end else if (elig[pos_s] && !b_vld && !clash[a_idx][pos_s]) begin
        // a_vld is already set here, so a_idx names A's winner
        b_vld = 1'b1;
        b_idx = pos_s;
      end else begin
        b_vld = b_vld;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one dual-port operand RAM (registered read, one
// cycle) between N_REQ requesters. Up to two commands are granted per cycle,
// one per RAM port, with round-robin fairness. Same-address dual writes are
// never issued together. Read data is steered back to the owning requester
// two cycles after the request was sampled.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req/we/addr/wdata     per-requester command (slice i at [i*W +: W])
//   gnt                   1-cycle pulse: command is on the RAM this cycle
//   rvalid/rdata          1-cycle read-return pulse, per-requester data
//   ram_a_* / ram_b_*     RAM port A / port B command and read data
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA  = DATA_DEF,
  parameter int ADDR  = ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      we,
  input  logic [N_REQ*ADDR-1:0] addr,
  input  logic [N_REQ*DATA-1:0] wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rvalid,
  output logic [N_REQ*DATA-1:0] rdata,
  output logic                  ram_a_w,
  output logic [ADDR-1:0]       ram_a_adbus,
  output logic [DATA-1:0]       ram_a_data_in,
  input  logic [DATA-1:0]       ram_a_data_out,
  output logic                  ram_b_w,
  output logic [ADDR-1:0]       ram_b_adbus,
  output logic [DATA-1:0]       ram_b_data_in,
  input  logic [DATA-1:0]       ram_b_data_out
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]         rr_ptr_r;
  logic [N_REQ-1:0]      gnt_r;
  logic [N_REQ-1:0]      elig_s;
  logic [N_REQ-1:0]      clash_s [N_REQ];
  logic                  a_vld_s, b_vld_s;
  logic [PW-1:0]         a_idx_s, b_idx_s;
  logic [N_REQ-1:0]      gnt_nxt_s;
  logic [PW-1:0]         ptr_nxt_s;
  logic                  a_we_s, b_we_s;
  logic [ADDR-1:0]       a_addr_s, b_addr_s;
  logic [DATA-1:0]       a_data_s, b_data_s;

  logic                  ram_a_w_r, ram_b_w_r;
  logic [ADDR-1:0]       ram_a_ad_r, ram_b_ad_r;
  logic [DATA-1:0]       ram_a_din_r, ram_b_din_r;

  // Read-return pipeline: stage 1 = command on RAM, stage 2 = data on RAM output.
  logic                  s1_a_vld_r, s1_b_vld_r, s2_a_vld_r, s2_b_vld_r;
  logic [PW-1:0]         s1_a_own_r, s1_b_own_r, s2_a_own_r, s2_b_own_r;
  logic [N_REQ-1:0]      rvalid_nxt_s;
  logic [N_REQ-1:0]      rvalid_r;
  logic [N_REQ*DATA-1:0] rdata_hold_r;
  logic [N_REQ*DATA-1:0] rdata_s;
  logic [DATA-1:0]       ram_dout_s [2];

  // A requester whose gnt is high this cycle has its held req consumed.
  assign elig_s = req & ~gnt_r;

  // Pairwise same-address write detection feeding the picker's skip mask.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      clash_s[i] = '0;
      for (int j = 0; j < N_REQ; j++) begin
        if ((i != j) && we[i] && we[j] &&
            (addr[i*ADDR +: ADDR] == addr[j*ADDR +: ADDR])) begin
          clash_s[i][j] = 1'b1;
        end else begin
          clash_s[i][j] = 1'b0;
        end
      end
    end
  end

  rr_pick2 #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .elig   (elig_s),
    .clash  (clash_s),
    .rr_ptr (rr_ptr_r),
    .a_vld  (a_vld_s),
    .a_idx  (a_idx_s),
    .b_vld  (b_vld_s),
    .b_idx  (b_idx_s)
  );

  // Gather the winners' commands, next grant vector and next scan pointer.
  always_comb begin
    a_we_s    = 1'b0;
    b_we_s    = 1'b0;
    a_addr_s  = '0;
    b_addr_s  = '0;
    a_data_s  = '0;
    b_data_s  = '0;
    gnt_nxt_s = '0;
    ptr_nxt_s = rr_ptr_r;
    for (int i = 0; i < N_REQ; i++) begin
      if (a_idx_s == PW'(i)) begin
        a_we_s   = we[i];
        a_addr_s = addr[i*ADDR +: ADDR];
        a_data_s = wdata[i*DATA +: DATA];
      end else begin
        a_we_s = a_we_s;
      end
      if (b_idx_s == PW'(i)) begin
        b_we_s   = we[i];
        b_addr_s = addr[i*ADDR +: ADDR];
        b_data_s = wdata[i*DATA +: DATA];
      end else begin
        b_we_s = b_we_s;
      end
    end
    if (a_vld_s) begin
      gnt_nxt_s[a_idx_s] = 1'b1;
      ptr_nxt_s          = PW'(wrap_inc(int'(a_idx_s), N_REQ));
    end else begin
      ptr_nxt_s = rr_ptr_r;
    end
    // B is always later in the scan than A, so it is the last granted index.
    if (b_vld_s) begin
      gnt_nxt_s[b_idx_s] = 1'b1;
      ptr_nxt_s          = PW'(wrap_inc(int'(b_idx_s), N_REQ));
    end else begin
      ptr_nxt_s = ptr_nxt_s;
    end
  end

  // Arbitration state and RAM command registers; idle port keeps addr/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      gnt_r       <= '0;
      ram_a_w_r   <= 1'b0;
      ram_a_ad_r  <= '0;
      ram_a_din_r <= '0;
      ram_b_w_r   <= 1'b0;
      ram_b_ad_r  <= '0;
      ram_b_din_r <= '0;
    end else begin
      rr_ptr_r <= ptr_nxt_s;
      gnt_r    <= gnt_nxt_s;
      if (a_vld_s) begin
        ram_a_w_r   <= a_we_s;
        ram_a_ad_r  <= a_addr_s;
        ram_a_din_r <= a_data_s;
      end else begin
        ram_a_w_r <= 1'b0;
      end
      if (b_vld_s) begin
        ram_b_w_r   <= b_we_s;
        ram_b_ad_r  <= b_addr_s;
        ram_b_din_r <= b_data_s;
      end else begin
        ram_b_w_r <= 1'b0;
      end
    end
  end

  // Stage-1 reads become next cycle's rvalid pulses.
  always_comb begin
    rvalid_nxt_s = '0;
    if (s1_a_vld_r) begin
      rvalid_nxt_s[s1_a_own_r] = 1'b1;
    end else begin
      rvalid_nxt_s = rvalid_nxt_s;
    end
    if (s1_b_vld_r) begin
      rvalid_nxt_s[s1_b_own_r] = 1'b1;
    end else begin
      rvalid_nxt_s = rvalid_nxt_s;
    end
  end

  // Owner/valid pipeline per port plus the per-requester held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_vld_r   <= 1'b0;
      s1_a_own_r   <= '0;
      s1_b_vld_r   <= 1'b0;
      s1_b_own_r   <= '0;
      s2_a_vld_r   <= 1'b0;
      s2_a_own_r   <= '0;
      s2_b_vld_r   <= 1'b0;
      s2_b_own_r   <= '0;
      rvalid_r     <= '0;
      rdata_hold_r <= '0;
    end else begin
      s1_a_vld_r   <= a_vld_s & ~a_we_s;
      s1_a_own_r   <= a_idx_s;
      s1_b_vld_r   <= b_vld_s & ~b_we_s;
      s1_b_own_r   <= b_idx_s;
      s2_a_vld_r   <= s1_a_vld_r;
      s2_a_own_r   <= s1_a_own_r;
      s2_b_vld_r   <= s1_b_vld_r;
      s2_b_own_r   <= s1_b_own_r;
      rvalid_r     <= rvalid_nxt_s;
      rdata_hold_r <= rdata_s;
    end
  end

  assign ram_dout_s[PORT_A] = ram_a_data_out;
  assign ram_dout_s[PORT_B] = ram_b_data_out;

  // Steer RAM output to the owner during its rvalid cycle, else hold.
  always_comb begin
    rdata_s = rdata_hold_r;
    for (int i = 0; i < N_REQ; i++) begin
      if (s2_a_vld_r && (s2_a_own_r == PW'(i))) begin
        rdata_s[i*DATA +: DATA] = ram_dout_s[PORT_A];
      end else if (s2_b_vld_r && (s2_b_own_r == PW'(i))) begin
        rdata_s[i*DATA +: DATA] = ram_dout_s[PORT_B];
      end else begin
        rdata_s[i*DATA +: DATA] = rdata_hold_r[i*DATA +: DATA];
      end
    end
  end

  assign gnt           = gnt_r;
  assign rvalid        = rvalid_r;
  assign rdata         = rdata_s;
  assign ram_a_w       = ram_a_w_r;
  assign ram_a_adbus   = ram_a_ad_r;
  assign ram_a_data_in = ram_a_din_r;
  assign ram_b_w       = ram_b_w_r;
  assign ram_b_adbus   = ram_b_ad_r;
  assign ram_b_data_in = ram_b_din_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural dual-port RAM
// (one-cycle registered read, read-before-write on the same address).
module tb_ram_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 256;
  localparam int AW = 2;

  localparam logic [DW-1:0] M0 = 256'h0123456789abcdeffedcba98765432100011223344556677_8899aabbccddeeff;
  localparam logic [DW-1:0] M1 = {8{32'hcafe0001}};
  localparam logic [DW-1:0] M2 = 256'h11;
  localparam logic [DW-1:0] M3 = 256'h0;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [N-1:0]      req;
  logic [N-1:0]      we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [N*DW-1:0]   rdata;
  logic              ram_a_w, ram_b_w;
  logic [AW-1:0]     ram_a_adbus, ram_b_adbus;
  logic [DW-1:0]     ram_a_data_in, ram_b_data_in;
  logic [DW-1:0]     ram_a_data_out, ram_b_data_out;
  logic [DW-1:0]     mem [4];

  int n_tests = 0;
  int n_fail  = 0;

  ram_port_arbiter #(.N_REQ(N), .DATA(DW), .ADDR(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .we             (we),
    .addr           (addr),
    .wdata          (wdata),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .ram_a_w        (ram_a_w),
    .ram_a_adbus    (ram_a_adbus),
    .ram_a_data_in  (ram_a_data_in),
    .ram_a_data_out (ram_a_data_out),
    .ram_b_w        (ram_b_w),
    .ram_b_adbus    (ram_b_adbus),
    .ram_b_data_in  (ram_b_data_in),
    .ram_b_data_out (ram_b_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural RAM; load reinstalls the preload image.
  always @(posedge clk) begin
    if (load) begin
      mem[0] <= M0;
      mem[1] <= M1;
      mem[2] <= M2;
      mem[3] <= M3;
    end else begin
      if (ram_a_w) mem[ram_a_adbus] <= ram_a_data_in;
      if (ram_b_w) mem[ram_b_adbus] <= ram_b_data_in;
    end
    ram_a_data_out <= mem[ram_a_adbus];
    ram_b_data_out <= mem[ram_b_adbus];
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]             = r;
    we[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return rdata[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] t3_word(input int i);
    case (i)
      0:       return M0;
      1:       return M1;
      2:       return M2;
      default: return '0;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_gnt"},    DW'(gnt),           DW'(3'b000));
    check_eq({tag, "_rvalid"}, DW'(rvalid),        DW'(3'b000));
    check_eq({tag, "_a_w"},    DW'(ram_a_w),       DW'(1'b0));
    check_eq({tag, "_a_ad"},   DW'(ram_a_adbus),   DW'(2'b00));
    check_eq({tag, "_a_din"},  ram_a_data_in,      '0);
    check_eq({tag, "_b_w"},    DW'(ram_b_w),       DW'(1'b0));
    check_eq({tag, "_b_ad"},   DW'(ram_b_adbus),   DW'(2'b00));
    check_eq({tag, "_b_din"},  ram_b_data_in,      '0);
    for (int i = 0; i < N; i++) check_eq({tag, "_rdata"}, rd(i), '0);
  endtask

  logic [N-1:0] prev_gnt;
  int           cnt [N];

  initial begin
    rst = 1'b1; load = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0; load = 1'b0;
    tick();

    // 1: single read of addr 1 by requester 0
    set_req(0, 1'b1, 1'b0, 2'd1, '0);
    tick();
    check_eq("t1_gnt",   DW'(gnt),         DW'(3'b001));
    check_eq("t1_a_w",   DW'(ram_a_w),     DW'(1'b0));
    check_eq("t1_a_ad",  DW'(ram_a_adbus), DW'(2'd1));
    check_eq("t1_rv_early", DW'(rvalid),   DW'(3'b000));
    set_req(0, 1'b0, 1'b0, 2'd0, '0);
    tick();
    check_eq("t1_rvalid", DW'(rvalid), DW'(3'b001));
    check_eq("t1_rdata",  rd(0),       M1);
    tick();
    check_eq("t1_rv_pulse", DW'(rvalid), DW'(3'b000));
    check_eq("t1_rd_hold",  rd(0),       M1);

    // 2: same-address dual write, pointer now at 1
    set_req(1, 1'b1, 1'b1, 2'd3, DW'(8'hAA));
    set_req(2, 1'b1, 1'b1, 2'd3, DW'(8'hBB));
    tick();
    check_eq("t2_gnt1",  DW'(gnt),         DW'(3'b010));
    check_eq("t2_a_w1",  DW'(ram_a_w),     DW'(1'b1));
    check_eq("t2_a_ad1", DW'(ram_a_adbus), DW'(2'd3));
    check_eq("t2_a_d1",  ram_a_data_in,    DW'(8'hAA));
    check_eq("t2_b_w1",  DW'(ram_b_w),     DW'(1'b0));
    set_req(1, 1'b0, 1'b0, 2'd0, '0);
    tick();
    check_eq("t2_gnt2", DW'(gnt),      DW'(3'b100));
    check_eq("t2_a_w2", DW'(ram_a_w),  DW'(1'b1));
    check_eq("t2_a_d2", ram_a_data_in, DW'(8'hBB));
    set_req(2, 1'b0, 1'b0, 2'd0, '0);
    tick();
    check_eq("t2_gnt_idle", DW'(gnt), DW'(3'b000));
    check_eq("t2_mem3",     mem[3],   DW'(8'hBB));
    set_req(0, 1'b1, 1'b0, 2'd3, '0);
    tick();
    set_req(0, 1'b0, 1'b0, 2'd0, '0);
    tick();
    check_eq("t2_rb_rvalid", DW'(rvalid), DW'(3'b001));
    check_eq("t2_rb_data",   rd(0),       DW'(8'hBB));
    check_eq("t2_idle_a_w",  DW'(ram_a_w),     DW'(1'b0));
    check_eq("t2_idle_a_ad", DW'(ram_a_adbus), DW'(2'd3));
    tick(); tick();

    // 3: continuous reads from all requesters for 30 cycles
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 1'b0, AW'(i), '0);
      cnt[i] = 0;
    end
    prev_gnt = '0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      check_eq("t3_back_to_back", DW'(gnt & prev_gnt), DW'(3'b000));
      prev_gnt = gnt;
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) cnt[i]++;
        if (rvalid[i]) check_eq("t3_rdata", rd(i), t3_word(i));
      end
    end
    req = '0;
    for (int i = 0; i < N; i++) check_eq("t3_grant_count", DW'(cnt[i]), DW'(32'd15));
    tick(); tick(); tick();

    // 4: write addr 2 and read addr 2 in the same cycle
    set_req(0, 1'b1, 1'b1, 2'd2, DW'(8'h55));
    set_req(1, 1'b1, 1'b0, 2'd2, '0);
    tick();
    check_eq("t4_gnt", DW'(gnt), DW'(3'b011));
    req = '0; we = '0;
    tick();
    check_eq("t4_rvalid",  DW'(rvalid), DW'(3'b010));
    check_eq("t4_old_data", rd(1),      DW'(8'h11));
    tick();
    set_req(1, 1'b1, 1'b0, 2'd2, '0);
    tick();
    set_req(1, 1'b0, 1'b0, 2'd0, '0);
    tick();
    check_eq("t4_new_rvalid", DW'(rvalid), DW'(3'b010));
    check_eq("t4_new_data",   rd(1),       DW'(8'h55));
    tick();

    // 5: reset while a granted read is in flight
    set_req(0, 1'b1, 1'b0, 2'd1, '0);
    tick();
    check_eq("t5_gnt", DW'(gnt), DW'(3'b001));
    rst = 1'b1;
    req = '0;
    tick();
    check_idle_outputs("t5_in_reset");
    tick();
    check_eq("t5_rvalid_late", DW'(rvalid), DW'(3'b000));
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
    tick();
    check_eq("t5_ptr_zero", DW'(gnt), DW'(3'b011));
    req = '0;
    tick(); tick(); tick();

    // 6: requester 2 holds req for six cycles
    set_req(2, 1'b1, 1'b0, 2'd0, '0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("t6_gnt2",   DW'(gnt[2]),    DW'((k % 2) == 1));
      check_eq("t6_rvalid2", DW'(rvalid[2]), DW'((k % 2) == 0));
      if ((k % 2) == 0) check_eq("t6_rdata2", rd(2), M0);
      if (k == 5) set_req(2, 1'b0, 1'b0, 2'd0, '0);
    end
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
